sa_result_collector: RTL and testbench
======================================

# sa_result_collector

Drain-side companion of the systolic-array input matrix feeder. After a matrix multiply, the array shifts its accumulated results out one column vector per shift. This block captures those vectors, rescales each accumulator from the ACC_W fixed-point format to the D_W format, and assembles them into a registered X_R×W_C result matrix. It then presents that matrix to the downstream stage (softmax / next MHA stage) through a valid/ready handshake.

## Interface
- D_W, 16: output element width; signed Q(D_W-FRAC).FRAC.
- ACC_W, 32: input accumulator width; signed Q(ACC_W-2·FRAC).(2·FRAC).
- FRAC, 8: fractional bits of one operand; also the rescale shift amount.
- X_R, 16: result rows, i.e. elements per input vector.
- W_C, 16: result columns, i.e. vectors per collection.

Ports:
- I_CLK  in  1: sole clock, rising edge.
- I_ASYN_RST  in  1: asynchronous, active-high reset.
- I_START  in  1: single-cycle pulse; arms a new collection.
- I_VALID  in  1: I_Y_VECTOR holds one column this cycle.
- I_Y_VECTOR  in  ACC_W ×[0:X_R-1]: column from the array; element i belongs to row i.
- I_READY  in  1: downstream accepts the matrix.
- O_BUSY  out  1: high in S_COLLECT.
- O_MAT_VALID  out  1: high in S_DONE; O_Y_MATRIX is complete and stable.
- O_OVERRUN  out  1: sticky; set when I_VALID arrives outside S_COLLECT.
- O_COL_CNT  out  16: number of columns captured in the current collection.
- O_Y_MATRIX  out  D_W ×[0:X_R-1][0:W_C-1]: registered result matrix.

## Operation
- States: S_IDLE, S_COLLECT, S_DONE. Reset state is S_IDLE.
- S_IDLE:
  - I_START → S_COLLECT, col←0, O_OVERRUN←0.
  - I_VALID without I_START sets O_OVERRUN.
- S_COLLECT:
  - Each cycle with I_VALID, write the converted column into O_Y_MATRIX[i][W_C-1-col] for all i, then col←col+1. The first vector out of the array is the rightmost column.
  - When the write lands at col==W_C-1 → S_DONE.
  - I_START in S_COLLECT restarts: col←0, and any I_VALID in that cycle is dropped.
  - I_VALID low: hold.
- S_DONE:
  - I_READY → S_IDLE.
  - I_START (with or without I_READY) → S_COLLECT, col←0.
  - I_VALID sets O_OVERRUN; the matrix is not modified.
- S_IDLE with I_START and I_VALID in the same cycle: start only; the vector is dropped and O_OVERRUN is not set.
- Matrix contents persist across collections until overwritten. They are not cleared by I_START.
- Conversion per element: take the signed ACC_W value and arithmetic-shift it right by FRAC. The result is narrowed to D_W per Configuration.
- O_COL_CNT = col. It holds W_C in S_DONE.

## Timing
- Reset values:
  - state S_IDLE, col 0.
  - O_BUSY 0, O_MAT_VALID 0, O_OVERRUN 0, O_COL_CNT 0.
  - every O_Y_MATRIX element 0.
- Capture latency: a column accepted at edge k is visible on O_Y_MATRIX after edge k.
- O_MAT_VALID rises at the same edge that writes the W_C-th column.
- Minimum collection: W_C consecutive cycles with I_VALID. Gaps are allowed.
- Handshake: the transfer completes on the edge where O_MAT_VALID && I_READY. O_MAT_VALID falls after that edge.
- I_READY while not in S_DONE is ignored.
- Reset asserted mid-collection: immediate return to reset values. The partial matrix is discarded (zeroed).

## Configuration
- SA_COLLECT_SAT_EN defined: after the shift, a value above 2^(D_W-1)-1 clamps to 0x7FFF (for D_W=16). A value below -2^(D_W-1) clamps to 0x8000.
- SA_COLLECT_SAT_EN undefined: plain truncation, element = acc[FRAC+D_W-1:FRAC]; upper bits are discarded and the value wraps.

## Test plan
- Reset check: assert I_ASYN_RST between edges → all outputs 0 immediately.
- Basic fill (X_R=W_C=4): I_START, then 4 back-to-back vectors where element i of vector c = (10·i+c)<<8.
  - O_Y_MATRIX[i][3-c] = 10·i+c.
  - O_MAT_VALID rises at the 4th capture edge.
  - O_COL_CNT=4.
- Handshake: hold I_READY=0 for 5 cycles → O_MAT_VALID and the matrix stay stable. Pulse I_READY → S_IDLE next cycle and O_MAT_VALID=0.
- Gaps and restart: send 2 vectors, idle 3 cycles, pulse I_START, send 4 vectors → O_COL_CNT resets to 0 and the final matrix reflects only the last 4 vectors.
- Overrun: I_VALID in S_IDLE, then in S_DONE → O_OVERRUN=1 and matrix unchanged. The next I_START clears O_OVERRUN.
- Rescale extremes, input 0x0100_0000 and 0xFF00_0000:
  - With SA_COLLECT_SAT_EN: 0x7FFF and 0x8000.
  - Without: 0x0000 and 0x0000 (wrap).
  - Input 0xFFFF_FF00 → 0xFFFF in both builds.

Source files
------------

// File: rtl/sa_result_collector_if.sv
// Handshake and data bundle between the systolic-array drain and the result collector.
// The DUT binds to slave; the array/downstream side binds to master.
interface sa_result_collector_if #(
    parameter int unsigned D_W   = 16,
    parameter int unsigned ACC_W = 32,
    parameter int unsigned X_R   = 16,
    parameter int unsigned W_C   = 16
);
    logic             I_START;
    logic             I_VALID;
    logic [ACC_W-1:0] I_Y_VECTOR [0:X_R-1];
    logic             I_READY;
    logic             O_BUSY;
    logic             O_MAT_VALID;
    logic             O_OVERRUN;
    logic [15:0]      O_COL_CNT;
    logic [D_W-1:0]   O_Y_MATRIX [0:X_R-1][0:W_C-1];

    modport master (
        output I_START, I_VALID, I_Y_VECTOR, I_READY,
        input  O_BUSY, O_MAT_VALID, O_OVERRUN, O_COL_CNT, O_Y_MATRIX
    );

    modport slave (
        input  I_START, I_VALID, I_Y_VECTOR, I_READY,
        output O_BUSY, O_MAT_VALID, O_OVERRUN, O_COL_CNT, O_Y_MATRIX
    );
endinterface

// File: rtl/sa_result_collector.sv
// Captures systolic-array result columns, rescales ACC_W -> D_W and presents the X_R x W_C matrix.
// Define SA_COLLECT_SAT_EN to saturate on rescale instead of wrapping.
module sa_result_collector #(
    parameter int unsigned D_W   = 16,
    parameter int unsigned ACC_W = 32,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned X_R   = 16,
    parameter int unsigned W_C   = 16
) (
    input logic                  I_CLK,
    input logic                  I_ASYN_RST,
    sa_result_collector_if.slave bus
);

    localparam int unsigned CW = (W_C > 1) ? $clog2(W_C) : 1;

`ifdef SA_COLLECT_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-D_W+1){1'b0}}, {(D_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-D_W+1){1'b1}}, {(D_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_e;

    state_e         state_q, state_d;
    logic [15:0]    col_q, col_d;
    logic           overrun_q, overrun_d;
    logic           wr_en;
    logic [CW-1:0]  wr_col;
    logic [D_W-1:0] mat_q [0:X_R-1][0:W_C-1];

    function automatic logic [D_W-1:0] conv(input logic [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sh;
        sh = $signed(acc) >>> FRAC;
`ifdef SA_COLLECT_SAT_EN
        if (sh > SAT_MAX) begin
            conv = {1'b0, {(D_W-1){1'b1}}};
        end else if (sh < SAT_MIN) begin
            conv = {1'b1, {(D_W-1){1'b0}}};
        end else begin
            conv = sh[D_W-1:0];
        end
`else
        conv = sh[D_W-1:0];
`endif
    endfunction

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        overrun_d = overrun_q;
        wr_en     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.I_START) begin
                    state_d   = S_COLLECT;
                    col_d     = '0;
                    overrun_d = 1'b0;
                end else if (bus.I_VALID) begin
                    overrun_d = 1'b1;
                end
            end
            S_COLLECT: begin
                // Restart wins over a coincident column; that column is dropped.
                if (bus.I_START) begin
                    col_d = '0;
                end else if (bus.I_VALID) begin
                    wr_en = 1'b1;
                    col_d = col_q + 16'd1;
                    if (col_q == 16'(W_C - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.I_START) begin
                    state_d   = S_COLLECT;
                    col_d     = '0;
                    overrun_d = 1'b0;
                end else begin
                    if (bus.I_VALID) begin
                        overrun_d = 1'b1;
                    end
                    if (bus.I_READY) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
        if (I_ASYN_RST) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            overrun_q <= overrun_d;
        end
    end

    // First column out of the array is the rightmost one.
    assign wr_col = CW'(W_C - 1) - col_q[CW-1:0];

    always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
        if (I_ASYN_RST) begin
            for (int unsigned i = 0; i < X_R; i++) begin
                for (int unsigned j = 0; j < W_C; j++) begin
                    mat_q[i][j] <= '0;
                end
            end
        end else if (wr_en) begin
            for (int unsigned i = 0; i < X_R; i++) begin
                mat_q[i][wr_col] <= conv(bus.I_Y_VECTOR[i]);
            end
        end
    end

    assign bus.O_BUSY      = (state_q == S_COLLECT);
    assign bus.O_MAT_VALID = (state_q == S_DONE);
    assign bus.O_OVERRUN   = overrun_q;
    assign bus.O_COL_CNT   = col_q;
    assign bus.O_Y_MATRIX  = mat_q;

endmodule

// File: tb/tb_sa_result_collector.sv
// Directed self-checking bench for sa_result_collector (4x4 matrix, both rescale builds).
module tb_sa_result_collector;

    localparam int unsigned D_W   = 16;
    localparam int unsigned ACC_W = 32;
    localparam int unsigned FRAC  = 8;
    localparam int unsigned X_R   = 4;
    localparam int unsigned W_C   = 4;
`ifdef SA_COLLECT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic I_CLK = 1'b0;
    logic I_ASYN_RST;
    always #5 I_CLK = ~I_CLK;

    sa_result_collector_if #(.D_W(D_W), .ACC_W(ACC_W), .X_R(X_R), .W_C(W_C)) bus ();

    sa_result_collector #(
        .D_W  (D_W),
        .ACC_W(ACC_W),
        .FRAC (FRAC),
        .X_R  (X_R),
        .W_C  (W_C)
    ) dut (
        .I_CLK     (I_CLK),
        .I_ASYN_RST(I_ASYN_RST),
        .bus       (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [15:0] exp_mat [0:X_R-1][0:W_C-1];
    logic [31:0] rin  [0:15];
    logic [15:0] rexp [0:15];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_mat(input string tag);
        for (int i = 0; i < X_R; i++)
            for (int j = 0; j < W_C; j++)
                chk($sformatf("%s[%0d][%0d]", tag, i, j), 32'(bus.O_Y_MATRIX[i][j]),
                    32'(exp_mat[i][j]));
    endtask

    task automatic step();
        @(posedge I_CLK);
        #1;
    endtask

    // Element i of column c = (base + 10*i + c) in Q.8 accumulator form.
    task automatic set_vec(input int base, input int c);
        for (int i = 0; i < X_R; i++) bus.I_Y_VECTOR[i] = 32'((base + 10 * i + c) << 8);
    endtask

    task automatic exp_col(input int base, input int c);
        for (int i = 0; i < X_R; i++) exp_mat[i][W_C-1-c] = 16'(base + 10 * i + c);
    endtask

    task automatic send(input int base, input int c);
        set_vec(base, c);
        bus.I_VALID = 1'b1;
        step();
        bus.I_VALID = 1'b0;
    endtask

    task automatic pulse_start();
        bus.I_START = 1'b1;
        step();
        bus.I_START = 1'b0;
    endtask

    task automatic pulse_ready();
        bus.I_READY = 1'b1;
        step();
        bus.I_READY = 1'b0;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < X_R; i++)
            for (int j = 0; j < W_C; j++) exp_mat[i][j] = '0;
    endtask

    initial begin
        bus.I_START = 1'b0;
        bus.I_VALID = 1'b0;
        bus.I_READY = 1'b0;
        for (int i = 0; i < X_R; i++) bus.I_Y_VECTOR[i] = '0;
        clear_exp();
        I_ASYN_RST = 1'b1;
        #22 I_ASYN_RST = 1'b0;
        #1;

        chk("rst_busy", 32'(bus.O_BUSY), 0);
        chk("rst_mvalid", 32'(bus.O_MAT_VALID), 0);
        chk("rst_overrun", 32'(bus.O_OVERRUN), 0);
        chk("rst_colcnt", 32'(bus.O_COL_CNT), 0);
        chk_mat("rst_mat");

        send(1, 0);
        chk("ovr_idle", 32'(bus.O_OVERRUN), 1);
        chk("ovr_idle_busy", 32'(bus.O_BUSY), 0);
        chk_mat("ovr_idle_mat");

        pulse_start();
        chk("start_busy", 32'(bus.O_BUSY), 1);
        chk("start_ovr_clr", 32'(bus.O_OVERRUN), 0);
        chk("start_colcnt", 32'(bus.O_COL_CNT), 0);

        for (int c = 0; c < 4; c++) begin
            send(0, c);
            exp_col(0, c);
            chk($sformatf("fill_colcnt%0d", c), 32'(bus.O_COL_CNT), 32'(c + 1));
            chk($sformatf("fill_mvalid%0d", c), 32'(bus.O_MAT_VALID), (c == 3) ? 1 : 0);
        end
        chk("fill_busy", 32'(bus.O_BUSY), 0);
        chk_mat("fill");

        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("hold_mvalid%0d", k), 32'(bus.O_MAT_VALID), 1);
            chk($sformatf("hold_m13_%0d", k), 32'(bus.O_Y_MATRIX[1][0]), 32'd13);
        end
        chk_mat("hold");

        send(70, 0);
        chk("ovr_done", 32'(bus.O_OVERRUN), 1);
        chk("ovr_done_mvalid", 32'(bus.O_MAT_VALID), 1);
        chk("done_colcnt", 32'(bus.O_COL_CNT), 4);
        chk_mat("ovr_done_mat");

        pulse_ready();
        chk("hs_mvalid", 32'(bus.O_MAT_VALID), 0);
        chk("hs_busy", 32'(bus.O_BUSY), 0);
        pulse_ready();
        chk("idle_ready_mvalid", 32'(bus.O_MAT_VALID), 0);
        chk("idle_ready_busy", 32'(bus.O_BUSY), 0);

        pulse_start();
        chk("restart_ovr_clr", 32'(bus.O_OVERRUN), 0);
        chk("restart_busy", 32'(bus.O_BUSY), 1);

        send(50, 0); exp_col(50, 0);
        send(50, 1); exp_col(50, 1);
        repeat (3) step();
        chk("gap_colcnt", 32'(bus.O_COL_CNT), 2);
        chk("gap_busy", 32'(bus.O_BUSY), 1);
        chk_mat("gap_partial");

        set_vec(90, 0);
        bus.I_VALID = 1'b1;
        pulse_start();
        bus.I_VALID = 1'b0;
        chk("restart_colcnt", 32'(bus.O_COL_CNT), 0);
        chk("restart_ovr", 32'(bus.O_OVERRUN), 0);
        chk_mat("restart_drop");

        for (int c = 0; c < 4; c++) begin
            send(20, c);
            exp_col(20, c);
            step();
        end
        chk("gapfill_mvalid", 32'(bus.O_MAT_VALID), 1);
        chk("gapfill_colcnt", 32'(bus.O_COL_CNT), 4);
        chk_mat("gapfill");
        pulse_ready();

        rin[0]  = 32'h0100_0000; rexp[0]  = SAT ? 16'h7FFF : 16'h0000;
        rin[1]  = 32'hFF00_0000; rexp[1]  = SAT ? 16'h8000 : 16'h0000;
        rin[2]  = 32'hFFFF_FF00; rexp[2]  = 16'hFFFF;
        rin[3]  = 32'h0000_1234; rexp[3]  = 16'h0012;
        rin[4]  = 32'h007F_FF00; rexp[4]  = 16'h7FFF;
        rin[5]  = 32'hFF80_0000; rexp[5]  = 16'h8000;
        rin[6]  = 32'h0080_0000; rexp[6]  = SAT ? 16'h7FFF : 16'h8000;
        rin[7]  = 32'hFF7F_FF00; rexp[7]  = SAT ? 16'h8000 : 16'h7FFF;
        rin[8]  = 32'hFFFF_8000; rexp[8]  = 16'hFF80;
        rin[9]  = 32'h0000_0000; rexp[9]  = 16'h0000;
        rin[10] = 32'h0000_00FF; rexp[10] = 16'h0000;
        rin[11] = 32'h7FFF_FFFF; rexp[11] = SAT ? 16'h7FFF : 16'hFFFF;
        rin[12] = 32'h8000_0000; rexp[12] = SAT ? 16'h8000 : 16'h0000;
        rin[13] = 32'hFFFF_FFFF; rexp[13] = 16'hFFFF;
        rin[14] = 32'h0001_0000; rexp[14] = 16'h0100;
        rin[15] = 32'hFFFF_0000; rexp[15] = 16'hFF00;

        pulse_start();
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < X_R; i++) begin
                bus.I_Y_VECTOR[i] = rin[c*4+i];
                exp_mat[i][W_C-1-c] = rexp[c*4+i];
            end
            bus.I_VALID = 1'b1;
            step();
            bus.I_VALID = 1'b0;
        end
        chk("rescale_mvalid", 32'(bus.O_MAT_VALID), 1);
        chk_mat("rescale");
        pulse_ready();

        pulse_start();
        send(30, 0);
        send(30, 1);
        chk("mid_colcnt", 32'(bus.O_COL_CNT), 2);
        #1 I_ASYN_RST = 1'b1;
        #1;
        clear_exp();
        chk("midrst_busy", 32'(bus.O_BUSY), 0);
        chk("midrst_mvalid", 32'(bus.O_MAT_VALID), 0);
        chk("midrst_overrun", 32'(bus.O_OVERRUN), 0);
        chk("midrst_colcnt", 32'(bus.O_COL_CNT), 0);
        chk_mat("midrst_mat");
        I_ASYN_RST = 1'b0;
        step();
        chk("postrst_busy", 32'(bus.O_BUSY), 0);
        chk("postrst_colcnt", 32'(bus.O_COL_CNT), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
